// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// The state enum, slice width and index-width helper live here so both modules agree.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble build still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// Shared 4-bit add slice: purely combinational sum of two nibbles plus carry-in.
module add4_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
    assign s    = full[NIB_W-1:0];
    assign co   = full[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by stepping one shared 4-bit slice across the operand, LSB nibble first.
// state | meaning
// IDLE  | ready for operands, req_ready high
// RUN   | one nibble added per cycle, carry held in carry_reg
// DONE  | result presented on rsp_*, held until rsp_ready
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    localparam int               IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_s;
    logic             slice_co;
    logic             slice_ovf;

    assign slice_a   = NIB_W'(a_reg >> (NIB_W * idx));
    assign slice_b   = NIB_W'(b_reg >> (NIB_W * idx));
    // Only meaningful on the top nibble, where slice_s[3] is the result sign bit.
    assign slice_ovf = (a_reg[W-1] == b_reg[W-1]) && (slice_s[NIB_W-1] != a_reg[W-1]);

    add4_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        sum       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[NIB_W*idx +: NIB_W] <= slice_s;
                    carry_reg               <= slice_co;
                    idx                     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= slice_co;
                        ovf       <= slice_ovf;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: 16-bit build with vectors, random ops and corner
// sequences, plus a single-nibble build for the minimum-latency case.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, cin, rsp_valid, rsp_ready, cout, ovf, busy;
    logic [15:0] a, b, sum;
    logic        req_valid1, req_ready1, cin1, rsp_valid1, rsp_ready1, cout1, ovf1, busy1;
    logic [3:0]  a1, b1, sum1;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .cin(cin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .a(a1), .b(b1), .cin(cin1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 17-bit addition; overflow from operand and result signs.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + 17'(c);
        v = (x[15] == y[15]) && (s[15] != x[15]);
        return {v, s};
    endfunction

    // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input int hold, input logic [15:0] es, input logic ec, input logic ev);
        int n;
        a = ta; b = tb; cin = tc; req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 5);
        for (int i = 0; i < hold; i++) begin
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_valid", 32'(rsp_valid), 1);
            @(negedge clk);
        end
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(ev));
        check("busy_done", 32'(busy), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("valid_drop", 32'(rsp_valid), 0);
        check("ready_back", 32'(req_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] m;
        logic [15:0] x, y;
        logic        c;
        int          n;
        int          seen;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1;
        req_valid = 1'b0; rsp_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        req_valid1 = 1'b0; rsp_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, vecs[i].s, vecs[i].co, vecs[i].v);

        // Abort in the second RUN cycle; cout/ovf are still 1 from the last vector.
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_busy_run", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", 32'(req_ready), 1);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        check("abort_ovf", 32'(ovf), 0);
        check("abort_busy", 32'(busy), 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0);

        // Backpressure with a second request held pending throughout DONE.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 32'(n), 5);
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_sum", 32'(sum), 32'h3333);
            check("bp_cout", 32'(cout), 0);
            check("bp_ovf", 32'(ovf), 0);
            check("bp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_valid", 32'(rsp_valid), 0);
        check("bp_idle_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_second_taken", 32'(req_ready), 0);
        check("bp_second_busy", 32'(busy), 1);
        m = model(16'h0F0F, 16'h0101, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp2_sum", 32'(sum), 32'(m[15:0]));
        check("bp2_cout", 32'(cout), 32'(m[16]));
        check("bp2_ovf", 32'(ovf), 32'(m[17]));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            c = 1'($urandom);
            if (i % 4 == 0) y = ~x;
            m = model(x, y, c);
            run_op(x, y, c, int'($urandom_range(0, 2)), m[15:0], m[16], m[17]);
        end

        // Single-nibble build: accept every 3 cycles, result 2 cycles after accept.
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; req_valid1 = 1'b1; rsp_ready1 = 1'b1;
        for (int c3 = 0; c3 < 9; c3++) begin
            check("n1_req_ready", 32'(req_ready1), 32'(c3 % 3 == 0));
            check("n1_rsp_valid", 32'(rsp_valid1), 32'(c3 % 3 == 2));
            if (c3 % 3 == 2) begin
                check("n1_sum", 32'(sum1), 0);
                check("n1_cout", 32'(cout1), 1);
                check("n1_ovf", 32'(ovf1), 0);
            end
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        rsp_ready1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs wide additions by time-sharing one 4-bit add slice across NIBBLES cycles, least-significant nibble first.
The nibble carry is held in a register between cycles.
Operands are accepted on a valid/ready request port, and the result is returned on a valid/ready response port.
Sits between a requesting datapath and a single shared 4-bit adder, trading latency for area.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  operands presented
req_ready  output  1  controller can accept operands (high only in IDLE)
a  input  W  operand A, unsigned or two's complement
b  input  W  operand B
cin  input  1  carry into nibble 0
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
sum  output  W  A+B+cin modulo 2^W
cout  output  1  carry out of the top nibble
ovf  output  1  signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: state=IDLE, req_ready=1 after the reset edge, rsp_valid=0, sum=0, cout=0, ovf=0, busy=0. The internal index and carry register also clear to 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture a and b into operand registers, carry_reg<=cin, idx<=0, sum register<=0, next state RUN.
  - Input ports are ignored after the capture edge.
- RUN, one nibble per cycle:
  - Slice inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg.
  - On the edge: sum[4*idx+:4]<=slice sum, carry_reg<=slice carry, idx<=idx+1.
  - When idx==NIBBLES-1, the next state is DONE instead, and cout<=slice carry.
  - ovf is registered at the same edge: ovf = (a_reg[W-1]==b_reg[W-1]) && (slice_sum[3]!=a_reg[W-1]).
- DONE:
  - rsp_valid=1. sum, cout and ovf are held stable while rsp_ready=0.
  - On rsp_ready: rsp_valid drops at the next edge and the state goes to IDLE.
- Latency: accept edge at cycle 0; rsp_valid is high from cycle NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles minimum, because req_ready is low in RUN and DONE.
- Simultaneous events:
  - req_valid during RUN or DONE is not accepted. The requester must hold it.
  - If rsp_ready and req_valid are both high in DONE, the new request is accepted in the following IDLE cycle.
- NIBBLES=1: RUN lasts exactly one cycle.
- Reset mid-operation: rst in RUN or DONE aborts the operation. Any in-flight or unconsumed result is discarded and all reset values apply at that edge.
- rst has priority over every handshake in the same cycle.
- Outputs are registered; there is no combinational path from req_* to rsp_*.
- Wrap-around: the sum is modulo 2^W. The carry beyond the top nibble appears only on cout.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE) as a 2-bit typedef;
  - localparam NIB_W=4;
  - a function computing the index width as clog2(NIBBLES), minimum 1.
- One sub-module: add4_slice, a purely combinational 4-bit add with carry-in. It has inputs a[3:0], b[3:0], ci and outputs s[3:0], co.
- The controller instantiates add4_slice exactly once.

Test Plan:
1. NIBBLES=4: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. rsp_valid rises exactly 5 cycles after the accept edge.
2. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. The carry ripples through all 4 nibbles across cycles.
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. Backpressure: hold rsp_ready=0 for 6 cycles in DONE -> sum, cout, ovf and rsp_valid are stable. A req_valid held high meanwhile is not accepted (req_ready=0). It is accepted in the IDLE cycle after rsp_ready is taken.
5. Reset mid-RUN: assert rst in the 2nd RUN cycle of a=0x00FF, b=0x0001 -> next cycle state=IDLE, req_ready=1, rsp_valid=0, sum=0. A fresh request then produces a correct result.
6. NIBBLES=1 build: a=0xF, b=0x1, cin=0 -> sum=0x0, cout=1. rsp_valid rises 2 cycles after accept. Back-to-back requests are accepted every 3 cycles.
